// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selects, hazard FSM states and the load-use test.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } hazard_state_t;

    // Register $0 never carries a real dependency, so it cannot cause a stall.
    function automatic logic isLoadUse(input logic memRead, input regbits_t regSel,
                                       input regbits_t rs, input regbits_t rt,
                                       input logic useRt);
        return memRead && (regSel != '0) &&
               ((regSel == rs) || (useRt && (regSel == rt)));
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the hazard unit, the datapath latches and the test bench.
interface hazard_unit_if import cpu_types_pkg::*; #(parameter int CNT_W = 32);

    logic             ihit;
    logic             dhit;
    logic             dmemREN_mem;
    logic             dmemWEN_mem;
    logic             memRead_ex;
    regbits_t         regSel_ex;
    regbits_t         rs_id;
    regbits_t         rt_id;
    logic             useRt_id;
    logic             redirect_ex;
    logic             halt_wb;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] dwait_cnt;

    modport hu (
        input  ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, regSel_ex,
               rs_id, rt_id, useRt_id, redirect_ex, halt_wb,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, dwait_cnt
    );

    modport dp (
        output ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, regSel_ex,
               rs_id, rt_id, useRt_id, redirect_ex, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted
    );

    modport tb (
        output ihit, dhit, dmemREN_mem, dmemWEN_mem, memRead_ex, regSel_ex,
               rs_id, rt_id, useRt_id, redirect_ex, halt_wb,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halted, stall_cnt, dwait_cnt
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline stall/flush controller: load-use bubbles, fetch and data-cache
// freezes, redirect squashes, sticky halt and saturating stall statistics.
module hazard_unit import cpu_types_pkg::*; #(
    parameter int CNT_W = 32
) (
    input  logic     CLK,
    input  logic     RST,
    hazard_unit_if.hu bus
);

    hazard_state_t state;
    logic          haltedQ;
    logic          dataReq;
    logic          dataWait;
    logic          loadUse;
    logic          allEn;
    logic          stallInc;
    logic          dwaitInc;
    logic          pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic          ifidFlush, idexFlush, exmemFlush;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] dwaitCnt;

    assign dataReq  = bus.dmemREN_mem | bus.dmemWEN_mem;
    // The dhit cycle itself is not a wait: every latch advances on it.
    assign dataWait = !bus.dhit && ((state == DWAIT) || ((state == RUN) && dataReq));
    assign loadUse  = isLoadUse(bus.memRead_ex, bus.regSel_ex, bus.rs_id,
                                bus.rt_id, bus.useRt_id);

    // Priority chain: earlier conditions mask everything below them.
    always_comb begin
        pcEn       = 1'b1;
        ifidEn     = 1'b1;
        idexEn     = 1'b1;
        exmemEn    = 1'b1;
        memwbEn    = 1'b1;
        ifidFlush  = 1'b0;
        idexFlush  = 1'b0;
        exmemFlush = 1'b0;
        if (RST || (state == HALTED) || dataWait) begin
            pcEn    = 1'b0;
            ifidEn  = 1'b0;
            idexEn  = 1'b0;
            exmemEn = 1'b0;
            memwbEn = 1'b0;
        end else if (bus.redirect_ex) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end else if (loadUse) begin
            pcEn      = 1'b0;
            ifidEn    = 1'b0;
            idexFlush = 1'b1;
        end else if (!bus.ihit) begin
            pcEn      = 1'b0;
            ifidFlush = 1'b1;
        end
    end

    assign allEn    = pcEn & ifidEn & idexEn & exmemEn & memwbEn;
    assign stallInc = !pcEn && !RST && (state != HALTED);
    assign dwaitInc = dataWait && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            haltedQ <= 1'b0;
        end else if (bus.halt_wb && allEn) begin
            state   <= HALTED;
            haltedQ <= 1'b1;
        end else begin
            case (state)
                RUN:     if (dataReq && !bus.dhit) state <= DWAIT;
                DWAIT:   if (bus.dhit) state <= RUN;
                HALTED:  state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) stallCounter (
        .CLK(CLK),
        .RST(RST),
        .inc(stallInc),
        .cnt(stallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) dwaitCounter (
        .CLK(CLK),
        .RST(RST),
        .inc(dwaitInc),
        .cnt(dwaitCnt)
    );

    assign bus.pc_en       = pcEn;
    assign bus.ifid_en     = ifidEn;
    assign bus.idex_en     = idexEn;
    assign bus.exmem_en    = exmemEn;
    assign bus.memwb_en    = memwbEn;
    assign bus.ifid_flush  = ifidFlush;
    assign bus.idex_flush  = idexFlush;
    assign bus.exmem_flush = exmemFlush;
    assign bus.halted      = haltedQ;
    assign bus.stall_cnt   = stallCnt;
    assign bus.dwait_cnt   = dwaitCnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a cycle-level reference model.
module tb_hazard_unit;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic CLK;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    hazard_unit_if #(.CNT_W(CW)) hzIf ();

    hazard_unit #(.CNT_W(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(hzIf.hu)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: "a data access is outstanding", "halted", two counts.
    bit modelValid = 0;
    bit mWaiting   = 0;
    bit mHalted    = 0;
    int mStall     = 0;
    int mDwait     = 0;

    function automatic bit waitNow();
        return (mWaiting || hzIf.dmemREN_mem || hzIf.dmemWEN_mem) && !hzIf.dhit;
    endfunction

    function automatic bit luNow();
        return hzIf.memRead_ex && (hzIf.regSel_ex != 0) &&
               ((hzIf.regSel_ex == hzIf.rs_id) ||
                (hzIf.useRt_id && (hzIf.regSel_ex == hzIf.rt_id)));
    endfunction

    // {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush, exmemFlush}
    function automatic logic [7:0] expCtl();
        if (RST || mHalted || waitNow()) return 8'b00000_000;
        if (hzIf.redirect_ex)            return 8'b11111_110;
        if (luNow())                     return 8'b00111_010;
        if (!hzIf.ihit)                  return 8'b01111_100;
        return 8'b11111_000;
    endfunction

    always @(posedge CLK) begin
        logic [7:0] ctl;
        ctl = expCtl();
        if (RST) begin
            modelValid = 1;
            mWaiting   = 0;
            mHalted    = 0;
            mStall     = 0;
            mDwait     = 0;
        end else if (!mHalted) begin
            if (waitNow() && mDwait < SAT) mDwait++;
            if (!ctl[7] && mStall < SAT) mStall++;
            if (hzIf.halt_wb && ctl[7:3] == 5'b11111) begin
                mHalted  = 1;
                mWaiting = 0;
            end else begin
                mWaiting = waitNow();
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (modelValid) begin
            checkOutput("ctl", 32'({hzIf.pc_en, hzIf.ifid_en, hzIf.idex_en, hzIf.exmem_en,
                                    hzIf.memwb_en, hzIf.ifid_flush, hzIf.idex_flush,
                                    hzIf.exmem_flush}), 32'(expCtl()));
            checkOutput("halted", 32'(hzIf.halted), 32'(mHalted));
            checkOutput("stall_cnt", 32'(hzIf.stall_cnt), 32'(mStall));
            checkOutput("dwait_cnt", 32'(hzIf.dwait_cnt), 32'(mDwait));
        end
    end

    // Drives one cycle of inputs just after the edge and returns at the
    // following falling edge, where the outputs are stable.
    task automatic applyStimulus(input logic rst, input logic ihit, input logic dhit,
                                 input logic ren, input logic wen, input logic memRead,
                                 input logic [4:0] regSel, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic useRt,
                                 input logic redirect, input logic halt);
        @(posedge CLK);
        #1;
        RST              = rst;
        hzIf.ihit        = ihit;
        hzIf.dhit        = dhit;
        hzIf.dmemREN_mem = ren;
        hzIf.dmemWEN_mem = wen;
        hzIf.memRead_ex  = memRead;
        hzIf.regSel_ex   = regSel;
        hzIf.rs_id       = rs;
        hzIf.rt_id       = rt;
        hzIf.useRt_id    = useRt;
        hzIf.redirect_ex = redirect;
        hzIf.halt_wb     = halt;
        @(negedge CLK);
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RST              = 1'b1;
        hzIf.ihit        = 1'b1;
        hzIf.dhit        = 1'b0;
        hzIf.dmemREN_mem = 1'b0;
        hzIf.dmemWEN_mem = 1'b0;
        hzIf.memRead_ex  = 1'b0;
        hzIf.regSel_ex   = '0;
        hzIf.rs_id       = '0;
        hzIf.rt_id       = '0;
        hzIf.useRt_id    = 1'b0;
        hzIf.redirect_ex = 1'b0;
        hzIf.halt_wb     = 1'b0;

        resetCycle();
        checkOutput("rst pc_en", 32'(hzIf.pc_en), 0);
        checkOutput("rst memwb_en", 32'(hzIf.memwb_en), 0);
        idle();
        checkOutput("reset stall", 32'(hzIf.stall_cnt), 0);
        checkOutput("reset dwait", 32'(hzIf.dwait_cnt), 0);
        checkOutput("reset halted", 32'(hzIf.halted), 0);
        checkOutput("idle pc_en", 32'(hzIf.pc_en), 1);

        // Load-use on rs, then $0 destination, then rt with and without useRt.
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0);
        checkOutput("lu pc_en", 32'(hzIf.pc_en), 0);
        checkOutput("lu ifid_en", 32'(hzIf.ifid_en), 0);
        checkOutput("lu idex_flush", 32'(hzIf.idex_flush), 1);
        checkOutput("lu idex_en", 32'(hzIf.idex_en), 1);
        idle();
        checkOutput("lu stall", 32'(hzIf.stall_cnt), 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("lu r0 pc_en", 32'(hzIf.pc_en), 1);
        checkOutput("lu r0 idex_flush", 32'(hzIf.idex_flush), 0);
        applyStimulus(0, 1, 0, 0, 0, 1, 7, 3, 7, 0, 0, 0);
        checkOutput("lu rt unused pc_en", 32'(hzIf.pc_en), 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0);
        checkOutput("lu rt used pc_en", 32'(hzIf.pc_en), 0);
        idle();
        checkOutput("lu stall 2", 32'(hzIf.stall_cnt), 2);

        // Three-cycle data miss, then the hit cycle advances everything.
        resetCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("miss pc_en", 32'(hzIf.pc_en), 0);
            checkOutput("miss memwb_en", 32'(hzIf.memwb_en), 0);
        end
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("hit pc_en", 32'(hzIf.pc_en), 1);
        checkOutput("hit memwb_en", 32'(hzIf.memwb_en), 1);
        idle();
        checkOutput("miss dwait", 32'(hzIf.dwait_cnt), 3);
        checkOutput("miss stall", 32'(hzIf.stall_cnt), 3);

        // Redirect held off by a data wait, taken on the hit cycle.
        applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("wait redirect pc_en", 32'(hzIf.pc_en), 0);
        checkOutput("wait redirect ifid_flush", 32'(hzIf.ifid_flush), 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("hit redirect pc_en", 32'(hzIf.pc_en), 1);
        checkOutput("hit redirect ifid_flush", 32'(hzIf.ifid_flush), 1);
        idle();
        checkOutput("wait redirect stall", 32'(hzIf.stall_cnt), 4);

        // Redirect beats a fetch miss; a plain fetch miss stalls the PC.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("redir imiss pc_en", 32'(hzIf.pc_en), 1);
        checkOutput("redir imiss ifid_flush", 32'(hzIf.ifid_flush), 1);
        checkOutput("redir imiss idex_flush", 32'(hzIf.idex_flush), 1);
        idle();
        checkOutput("redir stall unchanged", 32'(hzIf.stall_cnt), 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("imiss pc_en", 32'(hzIf.pc_en), 0);
        checkOutput("imiss ifid_flush", 32'(hzIf.ifid_flush), 1);

        // Redirect beats load-use.
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 5, 0, 0, 1, 0);
        checkOutput("redir lu ifid_en", 32'(hzIf.ifid_en), 1);
        checkOutput("redir lu pc_en", 32'(hzIf.pc_en), 1);
        checkOutput("redir lu idex_flush", 32'(hzIf.idex_flush), 1);
        idle();
        checkOutput("redir lu stall", 32'(hzIf.stall_cnt), 5);

        // Halt with no data request, then reset out of HALTED.
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt cycle pc_en", 32'(hzIf.pc_en), 1);
        idle();
        checkOutput("halted set", 32'(hzIf.halted), 1);
        checkOutput("halted pc_en", 32'(hzIf.pc_en), 0);
        idle();
        checkOutput("halted stall frozen", 32'(hzIf.stall_cnt), 5);
        resetCycle();
        idle();
        checkOutput("post halt halted", 32'(hzIf.halted), 0);
        checkOutput("post halt stall", 32'(hzIf.stall_cnt), 0);
        checkOutput("post halt pc_en", 32'(hzIf.pc_en), 1);

        // Halt alongside a store miss: taken only on the advancing hit cycle.
        applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt miss pc_en", 32'(hzIf.pc_en), 0);
        applyStimulus(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("halt hit halted", 32'(hzIf.halted), 0);
        checkOutput("halt hit pc_en", 32'(hzIf.pc_en), 1);
        idle();
        checkOutput("halt after hit", 32'(hzIf.halted), 1);
        checkOutput("halt after hit dwait", 32'(hzIf.dwait_cnt), 1);
        resetCycle();

        // Saturation of the 4-bit stall counter.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        idle();
        checkOutput("sat stall", 32'(hzIf.stall_cnt), 15);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        checkOutput("sat stall hold", 32'(hzIf.stall_cnt), 15);
        checkOutput("sat dwait", 32'(hzIf.dwait_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
